// File: rtl/hamming_secded_stream_decode_pkg.sv
// Shared types and width helpers for the SECDED Hamming codec family.
package hamming_secded_stream_decode_pkg;

    typedef enum logic [1:0] {
        HAM_OK            = 2'd0,
        HAM_CORRECTED     = 2'd1,
        HAM_UNCORRECTABLE = 2'd2
    } ham_status_t;

    // Smallest r with 2^r >= data_width + r + 1.
    function automatic int hamming_address_width(input int data_width);
        for (int r = 1; r < 31; r++) begin
            if ((1 << r) >= data_width + r + 1) return r;
        end
        return 31;
    endfunction

    function automatic int hamming_coded_width(input int data_width);
        return data_width + hamming_address_width(data_width) + 1;
    endfunction

    // Position 0 (overall parity) and every power of two carry parity.
    function automatic bit hamming_is_parity_pos(input int pos);
        return (pos & (pos - 1)) == 0;
    endfunction

endpackage

// File: rtl/hamming_secded_stream_decode_if.sv
// Codeword-in / payload-out stream pair with valid/ready on both sides.
interface hamming_secded_stream_decode_if #(
    parameter int DATA_WIDTH = 32
);
    import hamming_secded_stream_decode_pkg::*;

    localparam int ADDR_WIDTH  = hamming_address_width(DATA_WIDTH);
    localparam int CODED_WIDTH = hamming_coded_width(DATA_WIDTH);

    logic                   in_valid;
    logic                   in_ready;
    logic [CODED_WIDTH-1:0] in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    ham_status_t            out_status;
    logic [ADDR_WIDTH-1:0]  out_location;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_status, out_location
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_status, out_location
    );

endinterface

// File: rtl/hamming_secded_stream_decode_syndrome.sv
// Combinational syndrome (XOR of set-bit indices) and overall parity of a codeword.
module hamming_syndrome
    import hamming_secded_stream_decode_pkg::*;
#(
    parameter  int DATA_WIDTH  = 32,
    localparam int ADDR_WIDTH  = hamming_address_width(DATA_WIDTH),
    localparam int CODED_WIDTH = hamming_coded_width(DATA_WIDTH)
) (
    input  logic [CODED_WIDTH-1:0] code,
    output logic [ADDR_WIDTH-1:0]  syndrome,
    output logic                   parity
);

    always_comb begin
        syndrome = '0;
        for (int i = 0; i < CODED_WIDTH; i++) begin
            if (code[i]) syndrome = syndrome ^ ADDR_WIDTH'(i);
        end
    end

    assign parity = ^code;

endmodule

// File: rtl/hamming_secded_stream_decode.sv
// Two-stage streaming SECDED decoder with saturating corrected/uncorrectable counters.
module hamming_secded_stream_decode
    import hamming_secded_stream_decode_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit CORRECT_EN = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    hamming_secded_stream_decode_if.slave bus,
    input  logic                          cnt_clear,
    output logic [CNT_WIDTH-1:0]          corr_count,
    output logic [CNT_WIDTH-1:0]          uncorr_count
);

    localparam int ADDR_WIDTH  = hamming_address_width(DATA_WIDTH);
    localparam int CODED_WIDTH = hamming_coded_width(DATA_WIDTH);

    logic                   s1_valid;
    logic                   s1_par;
    logic [ADDR_WIDTH-1:0]  s1_syn;
    logic [CODED_WIDTH-1:0] s1_code;
    logic [ADDR_WIDTH-1:0]  syn_c;
    logic                   par_c;
    logic                   s1_adv;
    logic                   s2_adv;
    logic                   syn_in_range;
    ham_status_t            cls_status;
    logic [ADDR_WIDTH-1:0]  cls_loc;
    logic [CODED_WIDTH-1:0] flip_mask;
    logic [CODED_WIDTH-1:0] fixed_code;
    logic [DATA_WIDTH-1:0]  unpacked;

    hamming_syndrome #(.DATA_WIDTH(DATA_WIDTH)) u_syndrome (
        .code     (bus.in_data),
        .syndrome (syn_c),
        .parity   (par_c)
    );

    assign s2_adv      = !bus.out_valid || bus.out_ready;
    assign s1_adv      = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_par   <= 1'b0;
            s1_syn   <= '0;
            s1_code  <= '0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_par  <= par_c;
                s1_syn  <= syn_c;
                s1_code <= bus.in_data;
            end
        end
    end

    // Zero-extended so a coded width of exactly 2^ADDR_WIDTH still compares correctly.
    assign syn_in_range = {1'b0, s1_syn} < (ADDR_WIDTH + 1)'(CODED_WIDTH);

    always_comb begin
        cls_status = HAM_OK;
        cls_loc    = '0;
        flip_mask  = '0;
        if (s1_par) begin
            cls_loc = s1_syn;
            if (syn_in_range) begin
                cls_status = HAM_CORRECTED;
                if (CORRECT_EN) flip_mask = CODED_WIDTH'(1) << s1_syn;
            end else begin
                cls_status = HAM_UNCORRECTABLE;
            end
        end else if (s1_syn != '0) begin
            cls_status = HAM_UNCORRECTABLE;
            cls_loc    = s1_syn;
        end
    end

    assign fixed_code = s1_code ^ flip_mask;

    always_comb begin
        int k;
        unpacked = '0;
        k        = 0;
        for (int pos = 1; pos < CODED_WIDTH; pos++) begin
            if (!hamming_is_parity_pos(pos)) begin
                unpacked[k] = fixed_code[pos];
                k++;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_status   <= HAM_OK;
            bus.out_location <= '0;
        end else if (s2_adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_data     <= unpacked;
                bus.out_status   <= cls_status;
                bus.out_location <= cls_loc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clear) begin
            corr_count   <= '0;
            uncorr_count <= '0;
        end else if (bus.out_valid && bus.out_ready) begin
            if (bus.out_status == HAM_CORRECTED && corr_count != '1)
                corr_count <= corr_count + 1'b1;
            if (bus.out_status == HAM_UNCORRECTABLE && uncorr_count != '1)
                uncorr_count <= uncorr_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_secded_stream_decode.sv
// Bench for the streaming SECDED decoder: three variants driven in lockstep against an error-position model.
module tb_hamming_secded_stream_decode;
    import hamming_secded_stream_decode_pkg::*;

    localparam int DW = 32;
    localparam int CW = 39;

    typedef struct {
        logic [1:0]  st;
        logic [5:0]  loc;
        logic [31:0] da;
        logic [31:0] db;
    } exp_t;

    typedef struct {
        logic [38:0] clean;
        logic [38:0] mask;
        logic [1:0]  st;
        logic [5:0]  loc;
        logic [31:0] da;
        logic [31:0] db;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cnt_clear;
    logic [38:0] cur_clean;
    logic [38:0] cur_mask;
    logic [15:0] corr_a, uncorr_a, corr_b, uncorr_b;
    logic [1:0]  corr_c, uncorr_c;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    int   m_cw, m_uw, m_cn, m_un;

    hamming_secded_stream_decode_if #(.DATA_WIDTH(DW)) ifa ();
    hamming_secded_stream_decode_if #(.DATA_WIDTH(DW)) ifb ();
    hamming_secded_stream_decode_if #(.DATA_WIDTH(DW)) ifc ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = cur_clean ^ cur_mask;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = cur_clean ^ cur_mask;
    assign ifb.out_ready = out_ready;
    assign ifc.in_valid  = in_valid;
    assign ifc.in_data   = cur_clean ^ cur_mask;
    assign ifc.out_ready = out_ready;

    hamming_secded_stream_decode #(.DATA_WIDTH(DW), .CORRECT_EN(1'b1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa.slave), .cnt_clear(cnt_clear),
        .corr_count(corr_a), .uncorr_count(uncorr_a));
    hamming_secded_stream_decode #(.DATA_WIDTH(DW), .CORRECT_EN(1'b0), .CNT_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb.slave), .cnt_clear(cnt_clear),
        .corr_count(corr_b), .uncorr_count(uncorr_b));
    hamming_secded_stream_decode #(.DATA_WIDTH(DW), .CORRECT_EN(1'b1), .CNT_WIDTH(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc.slave), .cnt_clear(cnt_clear),
        .corr_count(corr_c), .uncorr_count(uncorr_c));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit is_par(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [38:0] encode(input logic [31:0] d);
        logic [38:0] c;
        logic        x;
        int          k;
        c = '0;
        k = 0;
        for (int p = 1; p < CW; p++) begin
            if (!is_par(p)) begin
                c[p] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 6; b++) begin
            x = 1'b0;
            for (int p = 1; p < CW; p++)
                if (((p >> b) & 1) == 1 && !is_par(p)) x ^= c[p];
            c[1 << b] = x;
        end
        c[0] = ^c[38:1];
        return c;
    endfunction

    function automatic logic [31:0] unpack(input logic [38:0] c);
        logic [31:0] d;
        int          k;
        d = '0;
        k = 0;
        for (int p = 1; p < CW; p++) begin
            if (!is_par(p)) begin
                d[k] = c[p];
                k++;
            end
        end
        return d;
    endfunction

    // Expectation from the injected error positions, not from the received word.
    function automatic exp_t make_exp(input logic [38:0] clean, input logic [38:0] mask);
        exp_t        e;
        int          n;
        int          syn;
        logic [38:0] raw;
        logic [38:0] fixed;
        n   = $countones(mask);
        syn = 0;
        for (int p = 0; p < CW; p++) if (mask[p]) syn ^= p;
        raw   = clean ^ mask;
        e.st  = 2'd0;
        e.loc = 6'd0;
        e.db  = unpack(raw);
        e.da  = e.db;
        if (n % 2 == 1) begin
            e.loc = 6'(syn);
            if (syn < CW) begin
                e.st       = 2'd1;
                fixed      = raw;
                fixed[syn] = ~fixed[syn];
                e.da       = unpack(fixed);
            end else begin
                e.st = 2'd2;
            end
        end else if (n != 0) begin
            e.st  = 2'd2;
            e.loc = 6'(syn);
        end
        return e;
    endfunction

    function automatic logic [38:0] rand_mask(input int n);
        logic [38:0] m;
        m = '0;
        while ($countones(m) < n) m[$urandom_range(38, 0)] = 1'b1;
        return m;
    endfunction

    function automatic int sat_inc(input int v, input int maxv);
        return (v < maxv) ? v + 1 : v;
    endfunction

    task automatic set_word(input logic [38:0] clean, input logic [38:0] mask);
        cur_clean = clean;
        cur_mask  = mask;
    endtask

    // One clock: check outputs/counters against the model, record handshakes, advance to next negedge.
    task automatic tick();
        exp_t e;
        #1;
        if (!rst_n) begin
            q.delete();
            m_cw = 0; m_uw = 0; m_cn = 0; m_un = 0;
        end else begin
            chk("corr_a", 64'(corr_a), 64'(m_cw));
            chk("uncorr_a", 64'(uncorr_a), 64'(m_uw));
            chk("corr_b", 64'(corr_b), 64'(m_cw));
            chk("uncorr_b", 64'(uncorr_b), 64'(m_uw));
            chk("corr_c", 64'(corr_c), 64'(m_cn));
            chk("uncorr_c", 64'(uncorr_c), 64'(m_un));
            if (ifa.out_valid) begin
                if (q.size() == 0) begin
                    chk("out_unexpected", 64'(q.size()), 64'd1);
                end else begin
                    e = q[0];
                    chk("a_data", 64'(ifa.out_data), 64'(e.da));
                    chk("a_status", 64'(ifa.out_status), 64'(e.st));
                    chk("a_loc", 64'(ifa.out_location), 64'(e.loc));
                end
            end
            if (ifb.out_valid && q.size() > 0) begin
                chk("b_data", 64'(ifb.out_data), 64'(q[0].db));
                chk("b_status", 64'(ifb.out_status), 64'(q[0].st));
                chk("b_loc", 64'(ifb.out_location), 64'(q[0].loc));
            end
            if (ifc.out_valid && q.size() > 0)
                chk("c_data", 64'(ifc.out_data), 64'(q[0].da));
            if (cnt_clear) begin
                m_cw = 0; m_uw = 0; m_cn = 0; m_un = 0;
            end
            if (ifa.out_valid && out_ready && q.size() > 0) begin
                e = q.pop_front();
                if (!cnt_clear) begin
                    if (e.st == 2'd1) begin
                        m_cw = sat_inc(m_cw, 65535);
                        m_cn = sat_inc(m_cn, 3);
                    end
                    if (e.st == 2'd2) begin
                        m_uw = sat_inc(m_uw, 65535);
                        m_un = sat_inc(m_un, 3);
                    end
                end
            end
            if (in_valid && ifa.in_ready) q.push_back(make_exp(cur_clean, cur_mask));
        end
        @(negedge clk);
    endtask

    vec_t        tbl[9];
    logic [38:0] sclean[8];
    logic [38:0] smask[8];

    initial begin
        tbl[0] = '{39'h0, 39'h0,            2'd0, 6'd0,  32'h0, 32'h0};
        tbl[1] = '{39'h0, 39'h20,           2'd1, 6'd5,  32'h0, 32'h2};
        tbl[2] = '{39'h0, 39'h28,           2'd2, 6'd6,  32'h3, 32'h3};
        tbl[3] = '{39'h0, 39'h1,            2'd1, 6'd0,  32'h0, 32'h0};
        tbl[4] = '{39'h0, 39'h1_0000_0180,  2'd2, 6'd47, 32'h8, 32'h8};
        tbl[5] = '{39'h0, 39'h40_0000_0000, 2'd1, 6'd38, 32'h0, 32'h8000_0000};
        tbl[6] = '{39'h0, 39'h6,            2'd2, 6'd3,  32'h0, 32'h0};
        tbl[7] = '{39'hF, 39'h0,            2'd0, 6'd0,  32'h1, 32'h1};
        tbl[8] = '{39'hF, 39'h8,            2'd1, 6'd3,  32'h1, 32'h0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;
        set_word('0, '0);
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_out_data", 64'(ifa.out_data), 64'd0);
        chk("rst_status", 64'(ifa.out_status), 64'd0);
        chk("rst_loc", 64'(ifa.out_location), 64'd0);
        chk("rst_corr", 64'(corr_a), 64'd0);
        chk("rst_uncorr", 64'(uncorr_a), 64'd0);
        chk("rst_in_ready", 64'(ifa.in_ready), 64'd1);

        // Directed table: exact 2-cycle latency and classification.
        for (int i = 0; i < 9; i++) begin
            set_word(tbl[i].clean, tbl[i].mask);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_early", i), 64'(ifa.out_valid), 64'd0);
            tick();
            chk($sformatf("tbl%0d_valid", i), 64'(ifa.out_valid), 64'd1);
            chk($sformatf("tbl%0d_status", i), 64'(ifa.out_status), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_loc", i), 64'(ifa.out_location), 64'(tbl[i].loc));
            chk($sformatf("tbl%0d_data_a", i), 64'(ifa.out_data), 64'(tbl[i].da));
            chk($sformatf("tbl%0d_data_b", i), 64'(ifb.out_data), 64'(tbl[i].db));
            chk($sformatf("tbl%0d_status_b", i), 64'(ifb.out_status), 64'(tbl[i].st));
            tick();
        end

        // Eight back-to-back words with the consumer stalled for cycles 3-6.
        for (int i = 0; i < 8; i++) begin
            sclean[i] = encode($urandom());
            smask[i]  = rand_mask($urandom_range(1, 0));
        end
        begin
            int sent;
            sent = 0;
            for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
                out_ready = !(c >= 3 && c <= 6);
                in_valid  = (sent < 8);
                if (sent < 8) set_word(sclean[sent], smask[sent]);
                #1;
                if (c >= 3 && c <= 7) chk($sformatf("stall_in_ready_c%0d", c), 64'(ifa.in_ready), 64'(c == 7));
                if (in_valid && ifa.in_ready) sent++;
                tick();
            end
            in_valid = 1'b0;
            chk("stall_sent", 64'(sent), 64'd8);
            chk("stall_drained", 64'(q.size()), 64'd0);
        end

        // Counter saturation on the 2-bit variant, then clear colliding with a delivery.
        out_ready = 1'b1;
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_word(encode($urandom()), rand_mask(1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("sat_corr_c", 64'(corr_c), 64'd3);
        chk("sat_corr_a", 64'(corr_a), 64'd5);
        set_word(encode($urandom()), rand_mask(1));
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("clr_word_valid", 64'(ifa.out_valid), 64'd1);
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        #1;
        chk("clr_corr_c", 64'(corr_c), 64'd0);
        chk("clr_corr_a", 64'(corr_a), 64'd0);

        // Reset mid-stream with words in flight.
        for (int i = 0; i < 3; i++) begin
            set_word(encode($urandom()), rand_mask(1));
            in_valid = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(ifa.out_valid), 64'd0);
        chk("mid_rst_corr", 64'(corr_a), 64'd0);
        chk("mid_rst_corr_c", 64'(corr_c), 64'd0);
        chk("mid_rst_in_ready", 64'(ifa.in_ready), 64'd1);
        tick();
        chk("mid_rst_no_ghost", 64'(ifa.out_valid), 64'd0);

        // Random traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(9, 0) < 7);
            out_ready = ($urandom_range(9, 0) < 7);
            cnt_clear = ($urandom_range(39, 0) == 0);
            set_word(encode($urandom()), rand_mask($urandom_range(3, 0)));
            tick();
        end
        in_valid  = 1'b0;
        cnt_clear = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        chk("rand_drained", 64'(q.size()), 64'd0);
        tick();
        chk("rand_idle", 64'(ifa.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_secded_stream_decode.md
Name: hamming_secded_stream_decode

Overview:
- Streaming, pipelined SECDED Hamming decoder with valid/ready handshakes on both sides.
- Recomputes syndrome and overall parity, corrects single-bit errors (when enabled), flags double and out-of-range errors, and unpacks the data bits.
- Keeps saturating corrected/uncorrectable event counters for status registers.
- Sits between a memory or link read port and the consumer, paired with the team's Hamming encoder.

Parameters:
- DATA_WIDTH, 32, payload width in bits (>=4).
- CORRECT_EN, 1, 1 = correct single errors; 0 = detect only (data passed uncorrected, status still reported).
- CNT_WIDTH, 16, width of each saturating error counter.
- ADDR_WIDTH, hamming_address_width(DATA_WIDTH), derived, not overridable; 6 for DATA_WIDTH=32.
- CODED_WIDTH, DATA_WIDTH+ADDR_WIDTH+1, derived; 39 for DATA_WIDTH=32.

Ports:
- clk  in  1  clock. One clock domain; all state is updated on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept a codeword.
- in_data  in  CODED_WIDTH  codeword. Bit 0 is the overall parity bit, bits at 2^k are Hamming parity bits, and the remaining positions hold data in ascending order (position 3 = data[0], 5 = data[1], 6 = data[2], 7 = data[3], 9 = data[4], ...).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_WIDTH  decoded payload.
- out_status  out  2  ham_status_t: OK=0, CORRECTED=1, UNCORRECTABLE=2; 3 is never driven.
- out_location  out  ADDR_WIDTH  syndrome (bit position of the error). 0 when status is OK.
- cnt_clear  in  1  synchronous clear of both counters.
- corr_count  out  CNT_WIDTH  number of CORRECTED results delivered.
- uncorr_count  out  CNT_WIDTH  number of UNCORRECTABLE results delivered.

Behaviour:
- Reset (rst_n=0 at a clock edge): both stage valids clear to 0, out_valid=0, out_data=0, out_status=OK, out_location=0, and both counters=0. Reset mid-stream drops all in-flight words. in_ready=1 in the cycle after reset.
- Pipeline stage S1 registers the syndrome (XOR of the indices of all set bits), the overall parity p (XOR of all CODED_WIDTH bits) and the raw codeword.
- Pipeline stage S2 registers the corrected/unpacked data, status and location; S2 drives the outputs.
- Latency is 2 cycles from the in_valid&in_ready edge to out_valid, with no stalls. Throughput is 1 word per cycle.
- Handshake:
  - s2_adv = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv (combinational, no combinational path from in_valid).
  - While out_valid=1 and out_ready=0, all outputs hold stable.
  - No bubbles are inserted when both sides are continuously ready.
- Classification, evaluated in S2 from the S1 registers:
  - syndrome==0, p==0: OK.
  - p==1, syndrome<CODED_WIDTH: CORRECTED, location=syndrome. Syndrome 0 means the overall parity bit itself flipped; data is untouched.
  - p==0, syndrome!=0: UNCORRECTABLE (double error), location=syndrome, data passed raw.
  - p==1, syndrome>=CODED_WIDTH: UNCORRECTABLE (odd multi-bit error), data passed raw.
- Correction: when CORRECT_EN=1 and the status is CORRECTED, invert codeword bit [syndrome] before unpacking. When CORRECT_EN=0, never invert; status and location are reported identically.
- Counters:
  - Increment on the out_valid&out_ready cycle according to out_status; each saturates at all-ones.
  - cnt_clear has priority over an increment in the same cycle; the result is 0.

Decomposition:
- gray_area_package holds:
  - hamming_address_width() (existing);
  - new functions hamming_coded_width() and hamming_is_parity_pos();
  - typedef enum logic[1:0] ham_status_t.
- Sub-module hamming_syndrome: combinational, parameter DATA_WIDTH. Takes the codeword and returns {syndrome, overall parity}. It is shared with the encoder's self-check and with this block's S1.

Test Plan (DATA_WIDTH=32, CNT_WIDTH=16 unless noted; clean codeword for payload 0 is all zeros):
- All-zero codeword, out_ready=1 -> out_valid 2 cycles later, out_data=0, status OK, location 0, counters unchanged.
- Zero codeword with bit 5 flipped -> status CORRECTED, location 5, out_data=0, corr_count=1. Same input with CORRECT_EN=0 -> out_data=0x00000002, status CORRECTED, location 5.
- Bits 3 and 5 flipped -> status UNCORRECTABLE, location 6, out_data=0x00000003, uncorr_count=1. Bit 0 alone flipped -> CORRECTED, location 0, out_data=0.
- Bits 7, 8 and 32 flipped (syndrome 47 >= 39, p=1) -> UNCORRECTABLE, location 47.
- Back-to-back stream of 8 words with out_ready low for cycles 3-6:
  - no word lost or duplicated, order preserved;
  - in_ready low once both stages are full;
  - outputs stable while stalled.
- CNT_WIDTH=2: five consecutive single-error words -> corr_count saturates at 3. Assert cnt_clear in the same cycle as a sixth accepted CORRECTED word -> 0. Assert rst_n low mid-stream -> out_valid=0 and counters=0 the next cycle.
